// File: rtl/sockit_spi_pkg.sv
// Shared types for the SPI sequencer: serializer command word, FSM states, IO modes, lane helpers.
package sockit_spi_pkg;

  localparam int CNT_W = 8;

  localparam logic [1:0] IOM_SGL0 = 2'd0;
  localparam logic [1:0] IOM_SGL1 = 2'd1;
  localparam logic [1:0] IOM_DUAL = 2'd2;
  localparam logic [1:0] IOM_QUAD = 2'd3;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             cke;
    logic [1:0]       iom;
    logic             die;
    logic             doe;
    logic             sso;
    logic             lst;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    DAT  = 2'd2,
    HLD  = 2'd3
  } seq_state_t;

  function automatic logic [2:0] lanes(input logic [1:0] iom);
    case (iom)
      IOM_DUAL: lanes = 3'd2;
      IOM_QUAD: lanes = 3'd4;
      default:  lanes = 3'd1;
    endcase
  endfunction

  function automatic logic [1:0] lane_shift(input logic [1:0] iom);
    case (iom)
      IOM_DUAL: lane_shift = 2'd1;
      IOM_QUAD: lane_shift = 2'd2;
      default:  lane_shift = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sockit_spi_seq_chunk.sv
// Chunk sizing: bits in the next serializer word and its lane-clock count.
module sockit_spi_seq_chunk
  import sockit_spi_pkg::*;
#(
  parameter int SDW = 32,
  parameter int LNW = 16
) (
  input  logic [LNW-1:0]   rem,
  input  logic [1:0]       iom,
  output logic [LNW-1:0]   bits,
  output logic [CNT_W-1:0] cnt,
  output logic             lst
);

  localparam logic [LNW-1:0] SDW_L = LNW'(SDW);
  localparam logic [LNW-1:0] ONE_L = LNW'(1'b1);

  // Clamp to one word and round up to whole lane groups
  always_comb begin
    lst  = (rem <= SDW_L);
    bits = lst ? rem : SDW_L;
    cnt  = CNT_W'((bits + LNW'(lanes(iom)) - ONE_L) >> lane_shift(iom));
  end

endmodule

// File: rtl/sockit_spi_seq.sv
// SPI command sequencer: one transfer request becomes a chain of per-word serializer commands.
// Define SOCKIT_SPI_SEQ_DLY_EN to add slave-select setup/hold commands around the data.
module sockit_spi_seq
  import sockit_spi_pkg::*;
#(
  parameter int SDW = 32,
  parameter int LNW = 16,
  parameter int SSD = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_vld,
  output logic           req_rdy,
  input  logic [LNW-1:0] req_len,
  input  logic [1:0]     req_iom,
  input  logic           req_dir,
  input  logic           req_sso,
  input  logic           wdt_vld,
  output logic           wdt_rdy,
  input  logic [SDW-1:0] wdt_dat,
  output logic           scw_vld,
  input  logic           scw_rdy,
  output cmd_t           scw_dat,
  output logic           sdw_vld,
  input  logic           sdw_rdy,
  output logic [SDW-1:0] sdw_dat,
  input  logic           sdr_vld,
  input  logic [SDW-1:0] sdr_dat,
  output logic           rdt_vld,
  output logic [SDW-1:0] rdt_dat,
  output logic           done
);

  localparam logic [CNT_W-1:0] SSD_CNT = CNT_W'(SSD);
  localparam logic [LNW-1:0]   ZERO_L  = {LNW{1'b0}};
  localparam logic [LNW-1:0]   ONE_L   = LNW'(1'b1);

  seq_state_t       state_q, state_d;
  logic [LNW-1:0]   rem_q, rem_d, rd_out_q, rd_out_d;
  logic [1:0]       iom_q, iom_d;
  logic             dir_q, dir_d, sso_q, sso_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             rdt_vld_q;
  logic [SDW-1:0]   rdt_dat_q;

  logic [LNW-1:0]   chk_bits_s;
  logic [CNT_W-1:0] chk_cnt_s;
  logic             chk_lst_s;
  cmd_t             cmd_s;
  logic             req_rdy_s, req_trn_s, scw_vld_s, rd_inc_s, rd_dec_s;
  // The serializer takes command and write word as one pair, so its sdw_rdy mirrors scw_rdy.
  logic [CNT_W:0]   unused_s;

  sockit_spi_seq_chunk #(.SDW(SDW), .LNW(LNW)) u_chunk (
    .rem  (rem_q),
    .iom  (iom_q),
    .bits (chk_bits_s),
    .cnt  (chk_cnt_s),
    .lst  (chk_lst_s)
  );

  assign req_rdy_s = (state_q == IDLE) & ~busy_q;
  assign req_trn_s = req_vld & req_rdy_s;

  // Next state, command decode and outstanding-read accounting
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    iom_d     = iom_q;
    dir_d     = dir_q;
    sso_d     = sso_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    scw_vld_s = 1'b0;
    rd_inc_s  = 1'b0;
    cmd_s.cnt = chk_cnt_s;
    cmd_s.cke = 1'b1;
    cmd_s.iom = iom_q;
    cmd_s.die = ~dir_q;
    cmd_s.doe = dir_q;
    cmd_s.sso = sso_q;
`ifdef SOCKIT_SPI_SEQ_DLY_EN
    cmd_s.lst = 1'b0;
`else
    cmd_s.lst = chk_lst_s;
`endif
    case (state_q)
      IDLE: begin
        if (req_trn_s) begin
          rem_d = req_len;
          iom_d = req_iom;
          dir_d = req_dir;
          sso_d = req_sso;
          if (req_len == ZERO_L) begin
            done_d = 1'b1;
          end else begin
            busy_d = 1'b1;
`ifdef SOCKIT_SPI_SEQ_DLY_EN
            state_d = SEL;
`else
            state_d = DAT;
`endif
          end
        end else begin
          state_d = IDLE;
        end
      end
`ifdef SOCKIT_SPI_SEQ_DLY_EN
      SEL: begin
        cmd_s.cnt = SSD_CNT;
        cmd_s.cke = 1'b0;
        cmd_s.die = 1'b0;
        cmd_s.doe = 1'b0;
        cmd_s.lst = 1'b0;
        scw_vld_s = 1'b1;
        state_d   = scw_rdy ? DAT : SEL;
      end
      HLD: begin
        cmd_s.cnt = SSD_CNT;
        cmd_s.cke = 1'b0;
        cmd_s.die = 1'b0;
        cmd_s.doe = 1'b0;
        cmd_s.lst = 1'b1;
        scw_vld_s = 1'b1;
        state_d   = scw_rdy ? IDLE : HLD;
      end
`endif
      DAT: begin
        scw_vld_s = ~dir_q | wdt_vld;
        rd_inc_s  = scw_vld_s & scw_rdy & ~dir_q;
        if (scw_vld_s && scw_rdy) begin
          rem_d = rem_q - chk_bits_s;
          if (chk_lst_s) begin
`ifdef SOCKIT_SPI_SEQ_DLY_EN
            state_d = HLD;
`else
            state_d = IDLE;
`endif
          end else begin
            state_d = DAT;
          end
        end else begin
          rem_d = rem_q;
        end
      end
      default: state_d = IDLE;
    endcase

    rd_dec_s = sdr_vld & ((rd_out_q != ZERO_L) | rd_inc_s);
    case ({rd_inc_s, rd_dec_s})
      2'b10:   rd_out_d = rd_out_q + ONE_L;
      2'b01:   rd_out_d = rd_out_q - ONE_L;
      default: rd_out_d = rd_out_q;
    endcase

    // Retire only once the FSM is home and every issued read word has come back
    if (busy_q && (state_d == IDLE) && (rd_out_d == ZERO_L)) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end else begin
      busy_d = busy_d;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= {LNW{1'b0}};
      rd_out_q  <= {LNW{1'b0}};
      iom_q     <= 2'd0;
      dir_q     <= 1'b0;
      sso_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdt_vld_q <= 1'b0;
      rdt_dat_q <= {SDW{1'b0}};
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      rd_out_q  <= rd_out_d;
      iom_q     <= iom_d;
      dir_q     <= dir_d;
      sso_q     <= sso_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rdt_vld_q <= sdr_vld;
      rdt_dat_q <= sdr_vld ? sdr_dat : rdt_dat_q;
    end
  end

  assign req_rdy  = req_rdy_s;
  assign scw_vld  = scw_vld_s;
  assign scw_dat  = cmd_s;
  assign sdw_vld  = scw_vld_s & cmd_s.doe;
  assign sdw_dat  = wdt_dat;
  assign wdt_rdy  = scw_rdy & scw_vld_s & cmd_s.doe;
  assign rdt_vld  = rdt_vld_q;
  assign rdt_dat  = rdt_dat_q;
  assign done     = done_q;
  assign unused_s = {sdw_rdy, SSD_CNT};

endmodule

// File: tb/tb_sockit_spi_seq.sv
// Self-checking bench for sockit_spi_seq (default build): scoreboard queues of expected commands, write words and read words.
module tb_sockit_spi_seq;
  import sockit_spi_pkg::*;

  localparam int SDW = 32;
  localparam int LNW = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_vld = 1'b0, req_rdy;
  logic [LNW-1:0] req_len = '0;
  logic [1:0]     req_iom = 2'd0;
  logic           req_dir = 1'b0, req_sso = 1'b0;
  logic           wdt_vld = 1'b0, wdt_rdy;
  logic [SDW-1:0] wdt_dat = '0;
  logic           scw_vld, scw_rdy = 1'b1;
  cmd_t           scw_dat;
  logic           sdw_vld, sdw_rdy = 1'b1;
  logic [SDW-1:0] sdw_dat;
  logic           sdr_vld = 1'b0;
  logic [SDW-1:0] sdr_dat = '0;
  logic           rdt_vld;
  logic [SDW-1:0] rdt_dat;
  logic           done;

  int n_cmp = 0;
  int n_err = 0;
  cmd_t           exp_cmd_q[$];
  logic [SDW-1:0] exp_sdw_q[$];
  logic [SDW-1:0] exp_rdt_q[$];

  always #5 clk = ~clk;

  sockit_spi_seq dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_len(req_len), .req_iom(req_iom),
    .req_dir(req_dir), .req_sso(req_sso),
    .wdt_vld(wdt_vld), .wdt_rdy(wdt_rdy), .wdt_dat(wdt_dat),
    .scw_vld(scw_vld), .scw_rdy(scw_rdy), .scw_dat(scw_dat),
    .sdw_vld(sdw_vld), .sdw_rdy(sdw_rdy), .sdw_dat(sdw_dat),
    .sdr_vld(sdr_vld), .sdr_dat(sdr_dat),
    .rdt_vld(rdt_vld), .rdt_dat(rdt_dat), .done(done)
  );

  function automatic cmd_t mk_cmd(input int cnt, input logic [1:0] iom, input logic dir, input logic lst);
    cmd_t c;
    c.cnt = CNT_W'(cnt);
    c.cke = 1'b1;
    c.iom = iom;
    c.die = ~dir;
    c.doe = dir;
    c.sso = 1'b1;
    c.lst = lst;
    return c;
  endfunction

  // Presents one request and returns on the falling edge after it was taken.
  task automatic send_req(input logic [LNW-1:0] len, input logic [1:0] iom, input logic dir, output logic ok);
    ok = 1'b0;
    @(negedge clk);
    req_len = len; req_iom = iom; req_dir = dir; req_sso = 1'b1; req_vld = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (req_rdy === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    req_vld = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    n_cmp++;
    if ({req_rdy, scw_vld, sdw_vld, wdt_rdy, rdt_vld, done} !== 6'b100000) begin
      n_err++;
      $display("FAIL reset_outputs got %b want 100000", {req_rdy, scw_vld, sdw_vld, wdt_rdy, rdt_vld, done});
    end
  endtask

  task automatic test_write64;
    logic ok;
    int done_cnt, wi;
    cmd_t exp_c;
    logic [SDW-1:0] exp_w;
    logic [SDW-1:0] words [2];
    words = '{32'hA5A5_0001, 32'h5A5A_0002};
    exp_cmd_q.delete(); exp_sdw_q.delete();
    exp_cmd_q.push_back(mk_cmd(32, 2'd1, 1'b1, 1'b0)); exp_sdw_q.push_back(words[0]);
    exp_cmd_q.push_back(mk_cmd(32, 2'd1, 1'b1, 1'b1)); exp_sdw_q.push_back(words[1]);
    scw_rdy = 1'b1; wdt_vld = 1'b1; wi = 0; wdt_dat = words[0]; done_cnt = 0;
    send_req(16'd64, 2'd1, 1'b1, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL wr64_req_accept got 0 want 1"); end
    for (int c = 0; c < 10; c++) begin
      wdt_dat = words[(wi < 2) ? wi : 1];
      #1;
      if (scw_vld && scw_rdy) begin
        n_cmp++;
        if (exp_cmd_q.size() == 0) begin
          n_err++; $display("FAIL wr64_extra_cmd got %h want none", scw_dat);
        end else begin
          exp_c = exp_cmd_q.pop_front(); exp_w = exp_sdw_q.pop_front();
          if (scw_dat !== exp_c || sdw_vld !== 1'b1 || sdw_dat !== exp_w || wdt_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL wr64_cmd got cmd=%h sdw=%b/%h wdt_rdy=%b want cmd=%h sdw=1/%h wdt_rdy=1",
                     scw_dat, sdw_vld, sdw_dat, wdt_rdy, exp_c, exp_w);
          end
        end
        wi++;
      end
      if (done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    wdt_vld = 1'b0;
    n_cmp++;
    if (exp_cmd_q.size() != 0) begin n_err++; $display("FAIL wr64_cmds_left got %0d want 0", exp_cmd_q.size()); end
    n_cmp++;
    if (done_cnt != 1) begin n_err++; $display("FAIL wr64_done got %0d pulses want 1", done_cnt); end
  endtask

  task automatic test_read40;
    logic ok, due;
    int done_cnt, done_c, last_rdt_c;
    cmd_t exp_c;
    logic [SDW-1:0] exp_r;
    exp_cmd_q.delete(); exp_rdt_q.delete();
    exp_cmd_q.push_back(mk_cmd(8, 2'd3, 1'b0, 1'b0));
    exp_cmd_q.push_back(mk_cmd(2, 2'd3, 1'b0, 1'b1));
    scw_rdy = 1'b1; wdt_vld = 1'b0; due = 1'b0;
    done_cnt = 0; done_c = -1; last_rdt_c = 100;
    send_req(16'd40, 2'd3, 1'b0, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rd40_req_accept got 0 want 1"); end
    for (int c = 0; c < 14; c++) begin
      sdr_vld = (c == 4 || c == 7);
      sdr_dat = (c == 4) ? 32'h1234_5678 : 32'h9ABC_DEF0;
      if (sdr_vld) exp_rdt_q.push_back(sdr_dat);
      #1;
      if (scw_vld && scw_rdy) begin
        n_cmp++;
        if (exp_cmd_q.size() == 0) begin
          n_err++; $display("FAIL rd40_extra_cmd got %h want none", scw_dat);
        end else begin
          exp_c = exp_cmd_q.pop_front();
          if (scw_dat !== exp_c || sdw_vld !== 1'b0 || wdt_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL rd40_cmd got cmd=%h sdw_vld=%b wdt_rdy=%b want cmd=%h 0 0", scw_dat, sdw_vld, wdt_rdy, exp_c);
          end
        end
      end
      n_cmp++;
      if (rdt_vld !== due) begin n_err++; $display("FAIL rd40_rdt_vld cycle %0d got %b want %b", c, rdt_vld, due); end
      if (rdt_vld === 1'b1 && exp_rdt_q.size() != 0) begin
        exp_r = exp_rdt_q.pop_front();
        last_rdt_c = c;
        n_cmp++;
        if (rdt_dat !== exp_r) begin n_err++; $display("FAIL rd40_rdt_dat got %h want %h", rdt_dat, exp_r); end
      end
      if (done === 1'b1) begin done_cnt++; done_c = c; end
      due = sdr_vld;
      @(negedge clk);
    end
    sdr_vld = 1'b0;
    n_cmp++;
    if (exp_cmd_q.size() != 0 || exp_rdt_q.size() != 0) begin
      n_err++; $display("FAIL rd40_left got cmds=%0d rdt=%0d want 0 0", exp_cmd_q.size(), exp_rdt_q.size());
    end
    n_cmp++;
    if (done_cnt != 1 || done_c < last_rdt_c) begin
      n_err++; $display("FAIL rd40_done got %0d pulses at %0d want 1 at/after %0d", done_cnt, done_c, last_rdt_c);
    end
  endtask

  task automatic test_wdt_stall;
    logic ok;
    int done_cnt, n_cmd;
    cmd_t exp_c;
    exp_c = mk_cmd(16, 2'd0, 1'b1, 1'b1);
    scw_rdy = 1'b1; wdt_vld = 1'b0; wdt_dat = 32'hBEEF_0000; done_cnt = 0; n_cmd = 0;
    send_req(16'd16, 2'd0, 1'b1, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL wstall_req_accept got 0 want 1"); end
    for (int c = 0; c < 10; c++) begin
      wdt_vld = (c >= 5);
      #1;
      if (c < 5) begin
        n_cmp++;
        if ({scw_vld, sdw_vld, wdt_rdy} !== 3'b000) begin
          n_err++; $display("FAIL wstall_idle cycle %0d got %b want 000", c, {scw_vld, sdw_vld, wdt_rdy});
        end
      end else if (scw_vld && scw_rdy) begin
        n_cmd++;
        n_cmp++;
        if (scw_dat !== exp_c || sdw_vld !== 1'b1 || sdw_dat !== 32'hBEEF_0000 || wdt_rdy !== 1'b1) begin
          n_err++;
          $display("FAIL wstall_pair got cmd=%h sdw=%b/%h want cmd=%h sdw=1/beef0000", scw_dat, sdw_vld, sdw_dat, exp_c);
        end
      end
      if (done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    wdt_vld = 1'b0;
    n_cmp++;
    if (n_cmd != 1 || done_cnt != 1) begin
      n_err++; $display("FAIL wstall_count got cmds=%0d done=%0d want 1 1", n_cmd, done_cnt);
    end
  endtask

  task automatic test_scw_stall;
    logic ok, stall;
    int done_cnt, wi;
    logic [SDW-1:0] words [3];
    words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    exp_cmd_q.delete(); exp_sdw_q.delete();
    for (int k = 0; k < 3; k++) begin
      exp_cmd_q.push_back(mk_cmd(16, 2'd2, 1'b1, (k == 2)));
      exp_sdw_q.push_back(words[k]);
    end
    scw_rdy = 1'b1; wdt_vld = 1'b1; wi = 0; done_cnt = 0;
    send_req(16'd96, 2'd2, 1'b1, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL sstall_req_accept got 0 want 1"); end
    for (int c = 0; c < 20; c++) begin
      stall   = (c >= 1 && c < 11);
      scw_rdy = ~stall;
      wdt_dat = words[(wi < 3) ? wi : 2];
      #1;
      if (stall) begin
        n_cmp++;
        if (scw_vld !== 1'b1 || wdt_rdy !== 1'b0) begin
          n_err++; $display("FAIL sstall_hold cycle %0d got vld=%b wdt_rdy=%b want 1 0", c, scw_vld, wdt_rdy);
        end
      end
      if (scw_vld === 1'b1) begin
        n_cmp++;
        if (exp_cmd_q.size() == 0) begin
          n_err++; $display("FAIL sstall_extra_cmd got %h want none", scw_dat);
        end else if (scw_dat !== exp_cmd_q[0] || sdw_dat !== exp_sdw_q[0]) begin
          n_err++;
          $display("FAIL sstall_cmd cycle %0d got %h/%h want %h/%h", c, scw_dat, sdw_dat, exp_cmd_q[0], exp_sdw_q[0]);
        end
        if (scw_rdy && exp_cmd_q.size() != 0) begin
          void'(exp_cmd_q.pop_front()); void'(exp_sdw_q.pop_front()); wi++;
        end
      end
      if (done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    scw_rdy = 1'b1; wdt_vld = 1'b0;
    n_cmp++;
    if (exp_cmd_q.size() != 0 || done_cnt != 1) begin
      n_err++; $display("FAIL sstall_end got left=%0d done=%0d want 0 1", exp_cmd_q.size(), done_cnt);
    end
  endtask

  task automatic test_zero_len;
    logic ok;
    scw_rdy = 1'b1;
    send_req(16'd0, 2'd0, 1'b1, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL zlen_req_accept got 0 want 1"); end
    #1;
    n_cmp++;
    if ({done, scw_vld} !== 2'b10) begin n_err++; $display("FAIL zlen_done got done/vld=%b want 10", {done, scw_vld}); end
    @(negedge clk); #1;
    n_cmp++;
    if ({done, scw_vld, req_rdy} !== 3'b001) begin
      n_err++; $display("FAIL zlen_after got done/vld/rdy=%b want 001", {done, scw_vld, req_rdy});
    end
  endtask

  task automatic test_reset_mid;
    logic ok;
    int done_cnt, n_cmd;
    cmd_t exp_c;
    scw_rdy = 1'b1; wdt_vld = 1'b0; sdr_vld = 1'b0;
    send_req(16'd64, 2'd1, 1'b0, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rstmid_req_accept got 0 want 1"); end
    #1;
    n_cmp++;
    if (scw_vld !== 1'b1) begin n_err++; $display("FAIL rstmid_first_cmd got %b want 1", scw_vld); end
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({scw_vld, sdw_vld, wdt_rdy, rdt_vld, done, req_rdy} !== 6'b000001) begin
      n_err++; $display("FAIL rstmid_outputs got %b want 000001", {scw_vld, sdw_vld, wdt_rdy, rdt_vld, done, req_rdy});
    end
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (done_cnt != 0) begin n_err++; $display("FAIL rstmid_spurious_done got %0d want 0", done_cnt); end
    exp_c = mk_cmd(32, 2'd0, 1'b0, 1'b1);
    exp_rdt_q.delete();
    n_cmd = 0;
    send_req(16'd32, 2'd0, 1'b0, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rstmid_new_req got 0 want 1"); end
    for (int c = 0; c < 10; c++) begin
      sdr_vld = (c == 3);
      sdr_dat = 32'hC0DE_0001;
      if (sdr_vld) exp_rdt_q.push_back(sdr_dat);
      #1;
      if (scw_vld && scw_rdy) begin
        n_cmd++;
        n_cmp++;
        if (scw_dat !== exp_c) begin n_err++; $display("FAIL rstmid_new_cmd got %h want %h", scw_dat, exp_c); end
      end
      if (rdt_vld === 1'b1 && exp_rdt_q.size() != 0) begin
        n_cmp++;
        if (rdt_dat !== exp_rdt_q[0]) begin n_err++; $display("FAIL rstmid_rdt got %h want %h", rdt_dat, exp_rdt_q[0]); end
        void'(exp_rdt_q.pop_front());
      end
      if (done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    sdr_vld = 1'b0;
    n_cmp++;
    if (n_cmd != 1 || done_cnt != 1 || exp_rdt_q.size() != 0) begin
      n_err++;
      $display("FAIL rstmid_new_xfer got cmds=%0d done=%0d rdt_left=%0d want 1 1 0", n_cmd, done_cnt, exp_rdt_q.size());
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_write64();
    test_read40();
    test_wdt_stall();
    test_scw_stall();
    test_zero_len();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
